// File: rtl/filter_cutoff_ctrl.sv
// Per-sample cut-off scheduler: base + envelope + LFO through one shared multiplier,
// slew-limited and handed to the moving-average filter as an order over valid/ready.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for a sample tick (or a tick left pending)
//   MUL_ENV | multiplier forms eg_amount * envelope
//   MUL_LFO | multiplier forms modulation * lfo_depth
//   SUM     | base + env_term + lfo_term, clamped to 0..65535
//   SLEW    | step order_out toward the target order
//   PRESENT | order_valid high, waiting for order_ready
module filter_cutoff_ctrl #(
   parameter int unsigned ORDER_MIN  = 1,
   parameter int unsigned ORDER_INIT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_tick,
   input  logic [15:0] cutoff_base,
   input  logic [15:0] eg_amount,
   input  logic [15:0] envelope,
   input  logic [15:0] modulation,
   input  logic [15:0] lfo_depth,
   input  logic [7:0]  slew_step,
   input  logic        order_ready,
   output logic [7:0]  order_out,
   output logic        order_valid,
   output logic        busy,
   output logic [7:0]  overrun_cnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MUL_ENV = 3'd1,
      MUL_LFO = 3'd2,
      SUM     = 3'd3,
      SLEW    = 3'd4,
      PRESENT = 3'd5
   } state_t;

   localparam logic [7:0] ORD_MIN  = 8'(ORDER_MIN);
   localparam logic [7:0] ORD_INIT = 8'(ORDER_INIT);

   state_t             state_q, state_d;
   logic [15:0]        base_q, base_d;
   logic [15:0]        eg_q, eg_d;
   logic [15:0]        env_q, env_d;
   logic [15:0]        mod_q, mod_d;
   logic [15:0]        depth_q, depth_d;
   logic [7:0]         slew_q, slew_d;
   logic [15:0]        env_term_q, env_term_d;
   logic signed [16:0] lfo_term_q, lfo_term_d;
   logic [15:0]        target_q, target_d;
   logic [7:0]         order_q, order_d;
   logic               valid_q, valid_d;
   logic               pending_q, pending_d;
   logic [7:0]         overrun_q, overrun_d;

   logic signed [16:0] mul_a, mul_b;
   logic signed [33:0] mul_p;
   logic signed [18:0] sum_w;
   logic [7:0]         tgt_ord;
   logic [7:0]         diff;
   logic [7:0]         step;
   logic               mul_unused;

   // Single multiplier: unsigned envelope product in MUL_ENV, signed LFO product otherwise.
   always_comb begin
      mul_a = 17'sd0;
      mul_b = 17'sd0;
      if (state_q == MUL_LFO) begin
         mul_a = signed'({mod_q[15], mod_q});
         mul_b = signed'({1'b0, depth_q});
      end else begin
         mul_a = signed'({1'b0, eg_q});
         mul_b = signed'({1'b0, env_q});
      end
   end

   assign mul_p      = 34'(mul_a) * 34'(mul_b);
   assign mul_unused = ^{mul_p[33], mul_p[15:0], target_q[7:0]};

   assign sum_w = signed'({3'b000, base_q}) + signed'({3'b000, env_term_q}) + 19'(lfo_term_q);

   assign tgt_ord = (target_q[15:8] < ORD_MIN) ? ORD_MIN : target_q[15:8];

   always_comb begin
      diff = 8'd0;
      step = 8'd0;
      if (tgt_ord >= order_q) begin
         diff = tgt_ord - order_q;
      end else begin
         diff = order_q - tgt_ord;
      end
      step = (diff < slew_q) ? diff : slew_q;
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      eg_d       = eg_q;
      env_d      = env_q;
      mod_d      = mod_q;
      depth_d    = depth_q;
      slew_d     = slew_q;
      env_term_d = env_term_q;
      lfo_term_d = lfo_term_q;
      target_d   = target_q;
      order_d    = order_q;
      valid_d    = valid_q;
      pending_d  = pending_q;
      overrun_d  = overrun_q;

      // A tick arriving outside IDLE (including on the handshake edge) is queued once, then counted as dropped.
      if (state_q != IDLE && sample_tick) begin
         if (!pending_q) begin
            pending_d = 1'b1;
         end else if (overrun_q != 8'hFF) begin
            overrun_d = overrun_q + 8'd1;
         end
      end

      case (state_q)
         IDLE: begin
            if (sample_tick || pending_q) begin
               base_d    = cutoff_base;
               eg_d      = eg_amount;
               env_d     = envelope;
               mod_d     = modulation;
               depth_d   = lfo_depth;
               slew_d    = slew_step;
               pending_d = 1'b0;
               state_d   = MUL_ENV;
            end
         end
         MUL_ENV: begin
            env_term_d = mul_p[31:16];
            state_d    = MUL_LFO;
         end
         MUL_LFO: begin
            lfo_term_d = mul_p[32:16];
            state_d    = SUM;
         end
         SUM: begin
            if (sum_w < 19'sd0) begin
               target_d = 16'h0000;
            end else if (sum_w > 19'sd65535) begin
               target_d = 16'hFFFF;
            end else begin
               target_d = sum_w[15:0];
            end
            state_d = SLEW;
         end
         SLEW: begin
            if (slew_q == 8'd0) begin
               order_d = tgt_ord;
            end else if (tgt_ord >= order_q) begin
               order_d = order_q + step;
            end else begin
               order_d = order_q - step;
            end
            valid_d = 1'b1;
            state_d = PRESENT;
         end
         PRESENT: begin
            if (order_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         base_q     <= 16'h0000;
         eg_q       <= 16'h0000;
         env_q      <= 16'h0000;
         mod_q      <= 16'h0000;
         depth_q    <= 16'h0000;
         slew_q     <= 8'h00;
         env_term_q <= 16'h0000;
         lfo_term_q <= 17'sd0;
         target_q   <= 16'h0000;
         order_q    <= ORD_INIT;
         valid_q    <= 1'b0;
         pending_q  <= 1'b0;
         overrun_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         eg_q       <= eg_d;
         env_q      <= env_d;
         mod_q      <= mod_d;
         depth_q    <= depth_d;
         slew_q     <= slew_d;
         env_term_q <= env_term_d;
         lfo_term_q <= lfo_term_d;
         target_q   <= target_d;
         order_q    <= order_d;
         valid_q    <= valid_d;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
      end
   end

   assign order_out   = order_q;
   assign order_valid = valid_q;
   assign busy        = (state_q != IDLE);
   assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_filter_cutoff_ctrl.sv
// Bench for filter_cutoff_ctrl: vector table through a scoreboard, plus handshake-hold,
// overrun, saturation and mid-update reset sequences.
module tb_filter_cutoff_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_tick;
   logic [15:0] cutoff_base, eg_amount, envelope, modulation, lfo_depth;
   logic [7:0]  slew_step;
   logic        order_ready;
   logic [7:0]  order_out;
   logic        order_valid;
   logic        busy;
   logic [7:0]  overrun_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [15:0] base;
      logic [15:0] eg;
      logic [15:0] env;
      logic [15:0] modv;
      logic [15:0] depth;
      logic [7:0]  slew;
      logic [7:0]  exp_ord;
   } vec_t;

   vec_t vt[16];

   filter_cutoff_ctrl #(.ORDER_MIN(1), .ORDER_INIT(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_tick (sample_tick),
      .cutoff_base (cutoff_base),
      .eg_amount   (eg_amount),
      .envelope    (envelope),
      .modulation  (modulation),
      .lfo_depth   (lfo_depth),
      .slew_step   (slew_step),
      .order_ready (order_ready),
      .order_out   (order_out),
      .order_valid (order_valid),
      .busy        (busy),
      .overrun_cnt (overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard: pop on every accepted handshake.
   always @(negedge clk) begin
      if (reset && order_valid && order_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_order", 32'(order_out), 32'hFFFF_FFFF);
         end else begin
            check("sb_order", 32'(order_out), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic apply(input vec_t v);
      cutoff_base = v.base;
      eg_amount   = v.eg;
      envelope    = v.env;
      modulation  = v.modv;
      lfo_depth   = v.depth;
      slew_step   = v.slew;
   endtask

   task automatic pulse_tick();
      @(posedge clk); #1 sample_tick = 1'b1;
      @(posedge clk); #1 sample_tick = 1'b0;
   endtask

   task automatic take();
      order_ready = 1'b1;
      @(posedge clk); #1 order_ready = 1'b0;
   endtask

   task automatic wait_valid(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         if (order_valid) break;
         @(posedge clk); #1;
      end
      check("valid_timeout", 32'(order_valid), 32'd1);
   endtask

   // Tick, then verify order_valid rises exactly four edges after the tick edge.
   task automatic tick_and_check_latency(input logic [7:0] exp_ord);
      exp_q.push_back(exp_ord);
      pulse_tick();
      repeat (3) begin @(posedge clk); #1; end
      check("valid_early", 32'(order_valid), 32'd0);
      @(posedge clk); #1;
      check("valid_latency", 32'(order_valid), 32'd1);
   endtask

   initial begin
      logic [7:0] held;
      vt[0]  = '{16'h1000, 16'h0000, 16'h0000, 16'h8000, 16'hFFFF, 8'h00, 8'h01};
      vt[1]  = '{16'h4000, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 8'h00, 8'hBF};
      vt[2]  = '{16'hF000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 8'h00, 8'hFF};
      vt[3]  = '{16'h2000, 16'h0000, 16'h0000, 16'h4000, 16'h8000, 8'h00, 8'h40};
      vt[4]  = '{16'h0200, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 8'h00, 8'h01};
      vt[5]  = '{16'h3000, 16'h4000, 16'hC000, 16'hC000, 16'h4000, 8'h00, 8'h50};
      vt[6]  = '{16'h12AB, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 8'h00, 8'h12};
      vt[7]  = '{16'h1000, 16'h0000, 16'h0000, 16'h8000, 16'hFFFF, 8'h00, 8'h01};
      vt[8]  = '{16'h4000, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 8'h10, 8'h11};
      vt[9]  = '{16'h4000, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 8'h10, 8'h21};
      vt[10] = '{16'h4000, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 8'h10, 8'h31};
      vt[11] = '{16'h4000, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 8'h10, 8'h41};
      vt[12] = '{16'h4000, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 8'h10, 8'h51};
      vt[13] = '{16'h4000, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 8'h00, 8'hBF};
      vt[14] = '{16'h1000, 16'h0000, 16'h0000, 16'h8000, 16'hFFFF, 8'h30, 8'h8F};
      vt[15] = '{16'h1000, 16'h0000, 16'h0000, 16'h8000, 16'hFFFF, 8'hFF, 8'h01};

      reset       = 1'b0;
      sample_tick = 1'b0;
      order_ready = 1'b0;
      apply(vt[0]);
      repeat (3) @(posedge clk);
      #1;
      check("rst_order_out", 32'(order_out), 32'h01);
      check("rst_valid", 32'(order_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun_cnt), 32'd0);
      reset = 1'b1;

      for (int i = 0; i < 16; i++) begin
         apply(vt[i]);
         tick_and_check_latency(vt[i].exp_ord);
         take();
      end

      // Handshake hold with order_ready low for 20 cycles.
      apply(vt[5]);
      tick_and_check_latency(8'h50);
      held = order_out;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         check("hold_order", 32'(order_out), 32'(held));
         check("hold_valid", 32'(order_valid), 32'd1);
         check("hold_busy", 32'(busy), 32'd1);
      end
      take();
      check("post_take_valid", 32'(order_valid), 32'd0);
      check("post_take_busy", 32'(busy), 32'd0);

      // Overrun: three ticks while the result is held.
      apply(vt[1]);
      exp_q.push_back(8'hBF);
      pulse_tick();
      wait_valid(10);
      pulse_tick();
      check("ovr_after_first", 32'(overrun_cnt), 32'd0);
      pulse_tick();
      pulse_tick();
      check("ovr_after_third", 32'(overrun_cnt), 32'd2);
      exp_q.push_back(8'hBF);
      take();
      wait_valid(10);
      take();
      repeat (10) @(posedge clk);
      #1;
      check("one_extra_busy", 32'(busy), 32'd0);
      check("one_extra_valid", 32'(order_valid), 32'd0);
      check("one_extra_queue", 32'(exp_q.size()), 32'd0);

      // Continuous ticks: one capture, one pending, the rest dropped until saturation.
      exp_q.push_back(8'hBF);
      exp_q.push_back(8'hBF);
      @(posedge clk); #1 sample_tick = 1'b1;
      repeat (305) @(posedge clk);
      #1 sample_tick = 1'b0;
      check("ovr_saturate", 32'(overrun_cnt), 32'd255);
      check("ovr_sat_valid", 32'(order_valid), 32'd1);
      take();
      wait_valid(10);
      take();
      check("ovr_sat_hold", 32'(overrun_cnt), 32'd255);

      // Reset while in SUM abandons the update.
      apply(vt[0]);
      pulse_tick();
      repeat (2) begin @(posedge clk); #1; end
      check("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("midrst_valid", 32'(order_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_order", 32'(order_out), 32'h01);
      check("midrst_overrun", 32'(overrun_cnt), 32'd0);
      @(posedge clk); #2;
      reset = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("post_rst_idle_valid", 32'(order_valid), 32'd0);
      apply(vt[1]);
      tick_and_check_latency(8'hBF);
      take();
      repeat (3) @(posedge clk);
      #1;
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running, required finished");
      $fatal(1, "timeout");
   end

endmodule
